// File: rtl/spi_master_cs_if.sv
// spi_master_cs_if
//  Groups the byte handshake and the SPI pins of spi_master_cs into one bundle.
//  master modport : the SPI master block (takes TX requests and MISO, drives RX results and SCLK/MOSI/CS_n)
//  slave modport  : whatever sits on the other side (issues TX requests, watches RX results and pins)
//  Signals:
//   i_TX_Count  CW  bytes in the burst, sampled on the first accepted byte
//   i_TX_Byte   8   byte to transmit
//   i_TX_DV     1   byte-valid strobe
//   o_TX_Ready  1   block accepts i_TX_DV this cycle
//   o_RX_DV     1   one-cycle pulse, o_RX_Byte is new
//   o_RX_Byte   8   received byte
//   o_RX_Count  CW  bytes received in the current burst
//   o_SPI_Clk   1   SCLK
//   i_SPI_MISO  1   MISO
//   o_SPI_MOSI  1   MOSI
//   o_SPI_CS_n  1   chip select, active low
interface spi_master_cs_if #(
    parameter int CW = 3
);
    logic [CW-1:0] i_TX_Count;
    logic [7:0]    i_TX_Byte;
    logic          i_TX_DV;
    logic          o_TX_Ready;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;
    logic [CW-1:0] o_RX_Count;
    logic          o_SPI_Clk;
    logic          i_SPI_MISO;
    logic          o_SPI_MOSI;
    logic          o_SPI_CS_n;

    modport master (
        input  i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count,
        output o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count,
        input  o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_master_cs.sv
// spi_master_cs
//  SPI master with chip-select burst control. Shifts whole bytes MSB-first on MOSI while
//  sampling MISO, keeps CS_n low for a burst of up to MAX_BYTES_PER_CS bytes and then
//  holds CS_n high for CS_INACTIVE_CLKS cycles before accepting the next burst.
//  Ports:
//   i_Clk  system clock, everything on its rising edge
//   i_Rst  synchronous reset, active high, aborts any transfer in progress
//   bus    spi_master_cs_if.master: byte handshake, RX results and the SPI pins
module spi_master_cs #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 4,
    parameter int CS_INACTIVE_CLKS  = 2,
    parameter int CW                = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    spi_master_cs_if.master bus
);
    localparam bit CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam bit CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int HW   = $clog2(CLKS_PER_HALF_BIT);
    localparam int GW   = $clog2(CS_INACTIVE_CLKS + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_INACTIVE_CLKS - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_BYTE, CS_GAP} state_t;

    state_t        state;
    logic [HW-1:0] clk_cnt;
    logic [4:0]    edge_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [CW-1:0] burst_len;
    logic [CW-1:0] next_count;
    logic          leading_edge;

    logic          spi_clk;
    logic          spi_mosi;
    logic          spi_cs_n;
    logic          tx_ready;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;

    assign next_count   = rx_count + CW'(1);
    // Odd-numbered SCLK edges (1st, 3rd, ...) are the leading edges of each bit.
    assign leading_edge = ~edge_cnt[0];

    // Burst FSM. In CPHA=0 the first bit is put on MOSI when the byte is taken, so the
    // shift register keeps only the remaining bits; in CPHA=1 the first leading edge
    // drives bit 7, so the whole byte is kept.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            spi_clk   <= CPOL;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            tx_ready  <= 1'b1;
            rx_dv     <= 1'b0;
            rx_byte   <= '0;
            rx_count  <= '0;
            clk_cnt   <= '0;
            edge_cnt  <= '0;
            gap_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            burst_len <= '0;
        end else begin
            rx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_TX_DV && tx_ready && (bus.i_TX_Count != '0)) begin
                        burst_len <= (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
                        rx_count  <= '0;
                        spi_cs_n  <= 1'b0;
                        tx_ready  <= 1'b0;
                        clk_cnt   <= '0;
                        edge_cnt  <= '0;
                        tx_shift  <= CPHA ? bus.i_TX_Byte : {bus.i_TX_Byte[6:0], 1'b0};
                        if (!CPHA) spi_mosi <= bus.i_TX_Byte[7];
                        state     <= XFER;
                    end
                end

                XFER: begin
                    if (edge_cnt == 5'd16) begin
                        rx_dv    <= 1'b1;
                        rx_byte  <= rx_shift;
                        rx_count <= next_count;
                        if (next_count < burst_len) begin
                            tx_ready <= 1'b1;
                            state    <= WAIT_BYTE;
                        end else begin
                            spi_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= CS_GAP;
                        end
                    end else if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= edge_cnt + 5'd1;
                        // Leading edge shifts out in CPHA=1 and samples in CPHA=0;
                        // the trailing edge does the opposite.
                        if (leading_edge == CPHA) begin
                            spi_mosi <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end else begin
                            rx_shift <= {rx_shift[6:0], bus.i_SPI_MISO};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + HW'(1);
                    end
                end

                WAIT_BYTE: begin
                    if (bus.i_TX_DV) begin
                        tx_ready <= 1'b0;
                        clk_cnt  <= '0;
                        edge_cnt <= '0;
                        tx_shift <= CPHA ? bus.i_TX_Byte : {bus.i_TX_Byte[6:0], 1'b0};
                        if (!CPHA) spi_mosi <= bus.i_TX_Byte[7];
                        state    <= XFER;
                    end
                end

                CS_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_SPI_Clk  = spi_clk;
    assign bus.o_SPI_MOSI = spi_mosi;
    assign bus.o_SPI_CS_n = spi_cs_n;
    assign bus.o_TX_Ready = tx_ready;
    assign bus.o_RX_DV    = rx_dv;
    assign bus.o_RX_Byte  = rx_byte;
    assign bus.o_RX_Count = rx_count;
endmodule

// File: tb/tb_spi_master_cs.sv
// tb_spi_master_cs
//  Bench for spi_master_cs. Instance A is mode 0, 2 clocks per half bit, MISO looped back
//  from MOSI. Instance B is mode 3, 4 clocks per half bit, with a slave model that
//  returns 0xC3. Transmitted bytes are queued as expected RX/MOSI results and popped
//  when the DUT produces them.
`timescale 1ns/1ps
module tb_spi_master_cs;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_cs_if #(.CW(CW)) ifA ();
    spi_master_cs_if #(.CW(CW)) ifB ();

    spi_master_cs #(
        .SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .MAX_BYTES_PER_CS(4), .CS_INACTIVE_CLKS(2)
    ) dutA (
        .i_Clk(clk), .i_Rst(rst), .bus(ifA)
    );

    spi_master_cs #(
        .SPI_MODE(3), .CLKS_PER_HALF_BIT(4), .MAX_BYTES_PER_CS(4), .CS_INACTIVE_CLKS(2)
    ) dutB (
        .i_Clk(clk), .i_Rst(rst), .bus(ifB)
    );

    logic misoB = 1'b0;
    assign ifA.i_SPI_MISO = ifA.o_SPI_MOSI;
    assign ifB.i_SPI_MISO = misoB;

    int vectors     = 0;
    int miscompares = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard for instance A: {expected RX count, expected byte} and expected MOSI bytes.
    logic [15:0] expRxA[$];
    logic [7:0]  expMosiA[$];
    logic [15:0] eRx;
    int          rxCntExp = 0;

    // Instance A monitor: scoreboard pops plus burst timing measurements.
    logic prevSclkA = 1'b0, prevCsA = 1'b1;
    int csLowRun = 0, edgeRunA = 0, riseRunA = 0, gapRun = 0;
    int lastCsLow = 0, lastRises = 0, lastGap = 0;
    int csRises = 0, csFalls = 0, rxPulsesA = 0, mosiBits = 0;
    logic [7:0] mosiShift = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            csLowRun = 0; edgeRunA = 0; riseRunA = 0; mosiBits = 0; gapRun = 0;
        end else begin
            if (ifA.o_RX_DV) begin
                rxPulsesA++;
                checkOutput("rxA_expected", 32'(expRxA.size() != 0), 32'd1);
                if (expRxA.size() != 0) begin
                    eRx = expRxA.pop_front();
                    checkOutput("rxA_byte", 32'(ifA.o_RX_Byte), 32'(eRx[7:0]));
                    checkOutput("rxA_count", 32'(ifA.o_RX_Count), 32'(eRx[15:8]));
                end
            end
            if (ifA.o_SPI_Clk != prevSclkA) begin
                edgeRunA++;
                if (ifA.o_SPI_Clk) begin
                    riseRunA++;
                    mosiShift = {mosiShift[6:0], ifA.o_SPI_MOSI};
                    mosiBits++;
                    if (mosiBits == 8) begin
                        mosiBits = 0;
                        checkOutput("mosiA_expected", 32'(expMosiA.size() != 0), 32'd1);
                        if (expMosiA.size() != 0)
                            checkOutput("mosiA_byte", 32'(mosiShift), 32'(expMosiA.pop_front()));
                    end
                end
            end
            if (!ifA.o_SPI_CS_n) csLowRun++;
            if (!ifA.o_SPI_CS_n && prevCsA) csFalls++;
            if (ifA.o_SPI_CS_n && !prevCsA) begin
                csRises++;
                lastCsLow = csLowRun;
                lastRises = riseRunA;
                csLowRun  = 0;
                riseRunA  = 0;
                edgeRunA  = 0;
            end
            if (ifA.o_SPI_CS_n && !ifA.o_TX_Ready) gapRun++;
            else if (gapRun != 0) begin
                lastGap = gapRun;
                gapRun  = 0;
            end
        end
        prevSclkA = ifA.o_SPI_Clk;
        prevCsA   = ifA.o_SPI_CS_n;
    end

    // Instance B slave model (mode 3): drive MISO on falling SCLK, capture MOSI on rising.
    logic prevSclkB = 1'b1, prevCsB = 1'b1;
    logic [7:0] slaveShiftB = 8'h00, slaveRxB = 8'h00;
    int risesB = 0, sinceRiseB = 0, lastPeriodB = 0, idleViolB = 0, rxPulsesB = 0;

    always @(negedge clk) begin
        if (!rst) begin
            sinceRiseB++;
            if (!ifB.o_SPI_CS_n && prevCsB) slaveShiftB = 8'hC3;
            if (ifB.o_SPI_Clk != prevSclkB) begin
                if (!ifB.o_SPI_Clk) begin
                    misoB       = slaveShiftB[7];
                    slaveShiftB = {slaveShiftB[6:0], 1'b0};
                end else begin
                    slaveRxB = {slaveRxB[6:0], ifB.o_SPI_MOSI};
                    if (risesB > 0) lastPeriodB = sinceRiseB;
                    risesB++;
                    sinceRiseB = 0;
                end
            end
            if (ifB.o_SPI_CS_n && (ifB.o_SPI_Clk !== 1'b1)) idleViolB++;
            if (ifB.o_RX_DV) rxPulsesB++;
        end
        prevSclkB = ifB.o_SPI_Clk;
        prevCsB   = ifB.o_SPI_CS_n;
    end

    // Bounded wait for instance A to be ready; a timeout counts as a failed comparison.
    task automatic waitReadyA(input string tag);
        int n = 0;
        while (!ifA.o_TX_Ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput(tag, 32'(ifA.o_TX_Ready), 32'd1);
    endtask

    // Hand one byte to instance A and queue its expected results.
    task automatic applyStimulus(input logic [7:0] b, input logic [CW-1:0] cnt, input bit first);
        waitReadyA("readyA_timeout");
        ifA.i_TX_Byte  = b;
        ifA.i_TX_Count = cnt;
        ifA.i_TX_DV    = 1'b1;
        if (first) rxCntExp = 0;
        rxCntExp++;
        expRxA.push_back({8'(rxCntExp), b});
        expMosiA.push_back(b);
        @(negedge clk);
        ifA.i_TX_DV = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int p0, r0, f0, n;

    initial begin
        ifA.i_TX_Count = '0; ifA.i_TX_Byte = '0; ifA.i_TX_DV = 1'b0;
        ifB.i_TX_Count = '0; ifB.i_TX_Byte = '0; ifB.i_TX_DV = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_csA",     32'(ifA.o_SPI_CS_n), 32'd1);
        checkOutput("reset_sclkA",   32'(ifA.o_SPI_Clk),  32'd0);
        checkOutput("reset_mosiA",   32'(ifA.o_SPI_MOSI), 32'd0);
        checkOutput("reset_readyA",  32'(ifA.o_TX_Ready), 32'd1);
        checkOutput("reset_rxdvA",   32'(ifA.o_RX_DV),    32'd0);
        checkOutput("reset_rxbyteA", 32'(ifA.o_RX_Byte),  32'd0);
        checkOutput("reset_rxcntA",  32'(ifA.o_RX_Count), 32'd0);
        checkOutput("reset_sclkB",   32'(ifB.o_SPI_Clk),  32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: mode 0 single byte loopback
        $display("[TB] single byte mode 0");
        p0 = rxPulsesA; r0 = csRises;
        applyStimulus(8'hA5, 3'd1, 1'b1);
        waitReadyA("t1_ready");
        settle();
        checkOutput("t1_rxdv_pulses", 32'(rxPulsesA - p0), 32'd1);
        checkOutput("t1_sclk_rises",  32'(lastRises),       32'd8);
        checkOutput("t1_cs_low_len",  32'(lastCsLow),       32'd33);
        checkOutput("t1_gap_len",     32'(lastGap),         32'd2);
        checkOutput("t1_cs_rises",    32'(csRises - r0),    32'd1);
        checkOutput("t1_cs_high",     32'(ifA.o_SPI_CS_n),  32'd1);
        checkOutput("t1_rx_byte",     32'(ifA.o_RX_Byte),   32'hA5);
        checkOutput("t1_rx_count",    32'(ifA.o_RX_Count),  32'd1);

        // Test 2: mode 3 with slave returning 0xC3
        $display("[TB] single byte mode 3");
        ifB.i_TX_Byte = 8'h3C; ifB.i_TX_Count = 3'd1; ifB.i_TX_DV = 1'b1;
        @(negedge clk);
        ifB.i_TX_DV = 1'b0;
        n = 0;
        while ((rxPulsesB == 0 || !ifB.o_TX_Ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("t2_timeout", 32'(ifB.o_TX_Ready), 32'd1);
        checkOutput("t2_rx_byte",   32'(ifB.o_RX_Byte),  32'hC3);
        checkOutput("t2_slave_rx",  32'(slaveRxB),       32'h3C);
        checkOutput("t2_rises",     32'(risesB),         32'd8);
        checkOutput("t2_period",    32'(lastPeriodB),    32'd8);
        checkOutput("t2_idle_high", 32'(idleViolB),      32'd0);
        checkOutput("t2_rx_pulses", 32'(rxPulsesB),      32'd1);
        checkOutput("t2_rx_count",  32'(ifB.o_RX_Count), 32'd1);

        // Test 3: three-byte burst with stalls
        $display("[TB] three byte burst");
        p0 = rxPulsesA; r0 = csRises; f0 = csFalls;
        applyStimulus(8'h01, 3'd3, 1'b1);
        waitReadyA("t3_ready1");
        repeat (10) @(negedge clk);
        checkOutput("t3_cs_low_stall1", 32'(ifA.o_SPI_CS_n), 32'd0);
        applyStimulus(8'h02, 3'd0, 1'b0);
        waitReadyA("t3_ready2");
        repeat (10) @(negedge clk);
        checkOutput("t3_cs_low_stall2", 32'(ifA.o_SPI_CS_n), 32'd0);
        applyStimulus(8'h03, 3'd0, 1'b0);
        waitReadyA("t3_ready3");
        settle();
        checkOutput("t3_cs_falls",   32'(csFalls - f0),    32'd1);
        checkOutput("t3_cs_rises",   32'(csRises - r0),    32'd1);
        checkOutput("t3_rx_pulses",  32'(rxPulsesA - p0),  32'd3);
        checkOutput("t3_rx_count",   32'(ifA.o_RX_Count),  32'd3);
        checkOutput("t3_gap_len",    32'(lastGap),         32'd2);

        // Test 4: strobes while not ready, then a zero-count request
        $display("[TB] ignored strobes");
        p0 = rxPulsesA; f0 = csFalls;
        applyStimulus(8'h96, 3'd1, 1'b1);
        repeat (10) @(negedge clk);
        ifA.i_TX_Byte = 8'hFF; ifA.i_TX_Count = 3'd1; ifA.i_TX_DV = 1'b1;
        @(negedge clk);
        ifA.i_TX_DV = 1'b0;
        n = 0;
        while (!ifA.o_SPI_CS_n && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("t4_cs_timeout", 32'(ifA.o_SPI_CS_n), 32'd1);
        checkOutput("t4_gap_ready", 32'(ifA.o_TX_Ready), 32'd0);
        ifA.i_TX_DV = 1'b1;
        @(negedge clk);
        ifA.i_TX_DV = 1'b0;
        waitReadyA("t4_ready");
        settle();
        checkOutput("t4_rx_pulses",  32'(rxPulsesA - p0),     32'd1);
        checkOutput("t4_cs_falls",   32'(csFalls - f0),       32'd1);
        checkOutput("t4_mosi_drain", 32'(expMosiA.size()),    32'd0);
        f0 = csFalls;
        ifA.i_TX_Byte = 8'h77; ifA.i_TX_Count = 3'd0; ifA.i_TX_DV = 1'b1;
        @(negedge clk);
        ifA.i_TX_DV = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("t4_zero_cs_falls", 32'(csFalls - f0),      32'd0);
        checkOutput("t4_zero_cs_high",  32'(ifA.o_SPI_CS_n),    32'd1);
        checkOutput("t4_zero_ready",    32'(ifA.o_TX_Ready),    32'd1);
        checkOutput("t4_count_hold",    32'(ifA.o_RX_Count),    32'd1);

        // Test 5: reset in the middle of a byte
        $display("[TB] reset mid byte");
        p0 = rxPulsesA;
        applyStimulus(8'hE7, 3'd1, 1'b1);
        n = 0;
        while (edgeRunA < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("t5_edge_timeout", 32'(edgeRunA), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_cs_high", 32'(ifA.o_SPI_CS_n), 32'd1);
        checkOutput("t5_sclk",    32'(ifA.o_SPI_Clk),  32'd0);
        checkOutput("t5_ready",   32'(ifA.o_TX_Ready), 32'd1);
        checkOutput("t5_rxdv",    32'(ifA.o_RX_DV),    32'd0);
        @(negedge clk);
        expRxA.delete();
        expMosiA.delete();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("t5_no_rxdv", 32'(rxPulsesA - p0), 32'd0);
        applyStimulus(8'h5A, 3'd1, 1'b1);
        waitReadyA("t5_ready_after");
        settle();
        checkOutput("t5_rx_pulses", 32'(rxPulsesA - p0),  32'd1);
        checkOutput("t5_rx_byte",   32'(ifA.o_RX_Byte),   32'h5A);
        checkOutput("t5_rx_count",  32'(ifA.o_RX_Count),  32'd1);

        // Test 6: count above the maximum saturates
        $display("[TB] count saturation");
        p0 = rxPulsesA; r0 = csRises;
        applyStimulus(8'h11, 3'd7, 1'b1);
        waitReadyA("t6_ready1");
        applyStimulus(8'h22, 3'd0, 1'b0);
        waitReadyA("t6_ready2");
        applyStimulus(8'h33, 3'd0, 1'b0);
        waitReadyA("t6_ready3");
        applyStimulus(8'h44, 3'd0, 1'b0);
        waitReadyA("t6_ready4");
        settle();
        checkOutput("t6_rx_count",  32'(ifA.o_RX_Count),  32'd4);
        checkOutput("t6_rx_pulses", 32'(rxPulsesA - p0),  32'd4);
        checkOutput("t6_cs_rises",  32'(csRises - r0),    32'd1);
        checkOutput("t6_cs_high",   32'(ifA.o_SPI_CS_n),  32'd1);
        checkOutput("t6_gap_len",   32'(lastGap),         32'd2);
        checkOutput("t6_rx_drain",  32'(expRxA.size()),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
